// File: rtl/pc_fetch_controller.sv
// Fetch-stage PC sequencer: owns the PC register and arbitrates trap/branch/jump redirects
// against stall and halt requests, driving imem address and pipeline flushes.
module pc_fetch_controller #(
    parameter int unsigned       WIDTH        = 32,
    parameter logic [WIDTH-1:0]  RESET_PC     = 32'h0000_0000,
    parameter logic [WIDTH-1:0]  TRAP_PC      = 32'h0000_0100,
    parameter int unsigned       FLUSH_CYCLES = 2,
    parameter int unsigned       IMEM_AW      = 12
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               stall_in,
    input  logic               md_busy,
    input  logic               br_taken,
    input  logic [WIDTH-1:0]   br_target,
    input  logic               jump,
    input  logic [WIDTH-1:0]   jump_target,
    input  logic               trap,
    input  logic               halt_in,
    output logic [WIDTH-1:0]   pc,
    output logic [WIDTH-1:0]   pc_plus1,
    output logic [IMEM_AW-1:0] address_imem,
    output logic               fetch_valid,
    output logic               flush_fd,
    output logic               flush_dx,
    output logic               halted
);

    typedef enum logic [1:0] {StRun, StStall, StFlush, StHalt} state_e;

    localparam logic [2:0] CntInit     = 3'(FLUSH_CYCLES - 1);
    localparam state_e     StAfterRedir = (FLUSH_CYCLES == 1) ? StRun : StFlush;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    // Flush cycles still owed, counting the current FLUSH cycle.
    logic [2:0]       cnt_q, cnt_d;
    logic             flush;
    logic             redirect;
    logic [WIDTH-1:0] pc_inc;

    assign pc_inc = pc_q + WIDTH'(1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StRun;
            pc_q    <= RESET_PC;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        cnt_d       = cnt_q;
        flush       = 1'b0;
        redirect    = 1'b0;
        fetch_valid = 1'b1;
        unique case (state_q)
            StRun, StStall: begin
                if (trap) begin
                    pc_d     = TRAP_PC;
                    redirect = 1'b1;
                end else if (br_taken) begin
                    pc_d     = br_target;
                    redirect = 1'b1;
                end else if (jump) begin
                    pc_d     = jump_target;
                    redirect = 1'b1;
                end else if (halt_in) begin
                    state_d = StHalt;
                end else if (stall_in || md_busy) begin
                    state_d     = StStall;
                    fetch_valid = 1'b0;
                end else begin
                    pc_d    = pc_inc;
                    state_d = StRun;
                end
                if (redirect) begin
                    flush   = 1'b1;
                    cnt_d   = CntInit;
                    state_d = StAfterRedir;
                end
            end
            StFlush: begin
                flush = 1'b1;
                if (trap) begin
                    pc_d    = TRAP_PC;
                    cnt_d   = CntInit;
                    state_d = StAfterRedir;
                end else begin
                    pc_d  = pc_inc;
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q <= 3'd1) begin
                        state_d = StRun;
                    end
                end
            end
            StHalt: begin
                fetch_valid = 1'b0;
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    assign pc           = pc_q;
    assign pc_plus1     = pc_inc;
    assign address_imem = pc_q[IMEM_AW-1:0];
    assign flush_fd     = flush;
    assign flush_dx     = flush;
    assign halted       = (state_q == StHalt);

endmodule

// File: tb/tb_pc_fetch_controller.sv
// Directed bench for pc_fetch_controller: hand-computed PC/flush/halt expectations.
module tb_pc_fetch_controller;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall_in, md_busy, br_taken, jump, trap, halt_in;
    logic [31:0] br_target, jump_target;
    logic [31:0] pc, pc_plus1;
    logic [11:0] address_imem;
    logic        fetch_valid, flush_fd, flush_dx, halted;

    int total = 0;
    int bad   = 0;

    pc_fetch_controller dut (
        .clock        (clock),
        .reset        (reset),
        .stall_in     (stall_in),
        .md_busy      (md_busy),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .jump         (jump),
        .jump_target  (jump_target),
        .trap         (trap),
        .halt_in      (halt_in),
        .pc           (pc),
        .pc_plus1     (pc_plus1),
        .address_imem (address_imem),
        .fetch_valid  (fetch_valid),
        .flush_fd     (flush_fd),
        .flush_dx     (flush_dx),
        .halted       (halted)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_flush(input string tag, input logic exp);
        check({tag, "_fd"}, {31'd0, flush_fd}, {31'd0, exp});
        check({tag, "_dx"}, {31'd0, flush_dx}, {31'd0, exp});
    endtask

    // Samples land on the falling edge; inputs also change there.
    task automatic step();
        @(negedge clock);
    endtask

    initial begin
        reset = 1'b1;
        {stall_in, md_busy, br_taken, jump, trap, halt_in} = '0;
        br_target   = '0;
        jump_target = '0;
        #3;
        check("rst_pc", pc, 32'h0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        step();
        step();
        reset = 1'b0;
        #1;
        check("rel_pc", pc, 32'h0);
        check("rel_fv", {31'd0, fetch_valid}, 32'd1);
        check_flush("rel_flush", 1'b0);

        // Free running
        for (int i = 1; i <= 5; i++) begin
            step();
            check("seq_pc", pc, 32'(i));
            check("seq_addr", {20'd0, address_imem}, 32'(i));
            check("seq_fv", {31'd0, fetch_valid}, 32'd1);
            check_flush("seq_flush", 1'b0);
        end

        // Branch at pc=5
        br_taken = 1'b1; br_target = 32'h40;
        #1 check_flush("br_accept", 1'b1);
        step();
        br_taken = 1'b0;
        #1;
        check("br_pc0", pc, 32'h40);
        check_flush("br_flush2", 1'b1);
        step();
        check("br_pc1", pc, 32'h41);
        check_flush("br_done", 1'b0);
        step();
        check("br_pc2", pc, 32'h42);

        // Jump to 6 to reach pc=8
        jump = 1'b1; jump_target = 32'h6;
        step();
        jump = 1'b0;
        #1 check("j6_pc", pc, 32'h6);
        step();
        check("j6_pc1", pc, 32'h7);
        step();
        check("j6_pc2", pc, 32'h8);

        // md_busy 3 cycles with a jump in the 2nd
        md_busy = 1'b1;
        #1;
        check("md_fv", {31'd0, fetch_valid}, 32'd0);
        check_flush("md_noflush", 1'b0);
        step();
        check("md_hold", pc, 32'h8);
        jump = 1'b1; jump_target = 32'h20;
        #1 check_flush("md_jump", 1'b1);
        step();
        jump = 1'b0;
        #1;
        check("md_jpc", pc, 32'h20);
        check_flush("md_flush2", 1'b1);
        step();
        md_busy = 1'b0;
        #1;
        check("md_ignored", pc, 32'h21);
        check_flush("md_flushdone", 1'b0);
        step();
        check("md_after", pc, 32'h22);

        // Trap beats branch, then trap again during FLUSH
        trap = 1'b1; br_taken = 1'b1; br_target = 32'h40;
        #1 check_flush("tr_accept", 1'b1);
        step();
        br_taken = 1'b0;
        #1;
        check("tr_pc", pc, 32'h100);
        check_flush("tr_flush2", 1'b1);
        step();
        trap = 1'b0;
        #1;
        check("tr_reload", pc, 32'h100);
        check_flush("tr_extend", 1'b1);
        step();
        check("tr_pc1", pc, 32'h101);
        check_flush("tr_done", 1'b0);

        // Wraparound
        jump = 1'b1; jump_target = 32'hFFFF_FFFE;
        step();
        jump = 1'b0;
        #1;
        check("wr_pc0", pc, 32'hFFFF_FFFE);
        check("wr_p1_0", pc_plus1, 32'hFFFF_FFFF);
        step();
        check("wr_pc1", pc, 32'hFFFF_FFFF);
        check("wr_p1_1", pc_plus1, 32'h0);
        step();
        check("wr_pc2", pc, 32'h0);
        check("wr_addr", {20'd0, address_imem}, 32'h0);

        // Halt at 0x10
        jump = 1'b1; jump_target = 32'hE;
        step();
        jump = 1'b0;
        step();
        step();
        check("h_pc", pc, 32'h10);
        halt_in = 1'b1;
        step();
        halt_in = 1'b0;
        #1;
        check("h_halted", {31'd0, halted}, 32'd1);
        check("h_fv", {31'd0, fetch_valid}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            br_taken = (i % 2 == 0);
            trap     = (i % 3 == 0);
            br_target = 32'h40;
            #1 check_flush("h_noflush", 1'b0);
            step();
            check("h_pc_held", pc, 32'h10);
            check("h_still", {31'd0, halted}, 32'd1);
        end
        br_taken = 1'b0; trap = 1'b0;

        // Async reset pulse between edges
        #2 reset = 1'b1;
        #1;
        check("ar_pc", pc, 32'h0);
        check("ar_halted", {31'd0, halted}, 32'd0);
        reset = 1'b0;
        step();
        check("ar_pc1", pc, 32'h1);
        check("ar_fv", {31'd0, fetch_valid}, 32'd1);

        // Stall in RUN, released: pc resumes
        stall_in = 1'b1;
        step();
        check("st_hold", pc, 32'h1);
        stall_in = 1'b0;
        step();
        check("st_resume", pc, 32'h2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
